// File: rtl/game_pkg.sv
// Shared types and parameter defaults for the game state controller.
// State codes are fixed so the exported state bus is stable across revisions.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_RESPAWN   = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_WIN       = 3'd4
    } state_t;

    localparam int LIVES_W            = 4;
    localparam int TIMER_W            = 8;
    localparam int DEF_INIT_LIVES     = 3;
    localparam int DEF_MAX_LIVES      = 9;
    localparam int DEF_RESPAWN_FRAMES = 60;

endpackage

// File: rtl/frame_timer.sv
// Loadable 8-bit frame down-counter used for the respawn delay.
// Latency: count updates one cycle after load/tick; expired is combinational on the expiring tick.
// Backpressure: none; ticks are never stalled.
module frame_timer
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               resetN,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic [TIMER_W-1:0] count,
    output logic [TIMER_W-1:0] count_nxt,
    output logic               expired
);

    // count_nxt is exported so the parent can register outputs derived from the timer
    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = load_val;
        end else if (tick && (count != '0)) begin
            count_nxt = count - TIMER_W'(1);
        end
    end

    assign expired = tick && !load && (count == TIMER_W'(1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/game_state_controller.sv
// Game flow FSM: lives bookkeeping, respawn countdown, game over / win detection.
// Latency: all outputs registered, visible one cycle after the triggering input is sampled.
// Backpressure: none; inputs are sampled every cycle and pulses are never queued.
module game_state_controller
    import game_pkg::*;
#(
    parameter int INIT_LIVES     = DEF_INIT_LIVES,
    parameter int MAX_LIVES      = DEF_MAX_LIVES,
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               start_game,
    input  logic               ball_lost,
    input  logic               bonus_life,
    input  logic               level_cleared,
    output logic [LIVES_W-1:0] lives,
    output logic [2:0]         state,
    output logic               ball_enable,
    output logic               respawn_pulse,
    output logic               flash,
    output logic               game_over,
    output logic               win
);

    state_t               st_q, st_nxt;
    logic [LIVES_W-1:0]   lives_nxt, lives_inc;
    logic                 pulse_nxt;
    logic                 lost_q;
    logic                 loss_edge;
    logic                 tmr_load;
    logic                 tmr_tick;
    logic                 tmr_expired;
    logic [TIMER_W-1:0]   tmr_count, tmr_count_nxt;

    assign loss_edge = ball_lost && !lost_q;
    assign tmr_tick  = startOfFrame && (st_q == ST_RESPAWN);
    assign lives_inc = (lives < LIVES_W'(MAX_LIVES)) ? lives + LIVES_W'(1) : LIVES_W'(MAX_LIVES);

    frame_timer u_frame_timer (
        .clk       (clk),
        .resetN    (resetN),
        .load      (tmr_load),
        .load_val  (TIMER_W'(RESPAWN_FRAMES)),
        .tick      (tmr_tick),
        .count     (tmr_count),
        .count_nxt (tmr_count_nxt),
        .expired   (tmr_expired)
    );

    always_comb begin
        st_nxt    = st_q;
        lives_nxt = lives;
        pulse_nxt = 1'b0;
        tmr_load  = 1'b0;
        case (st_q)
            ST_IDLE: begin
                lives_nxt = LIVES_W'(INIT_LIVES);
                if (start_game) begin
                    st_nxt    = ST_PLAY;
                    pulse_nxt = 1'b1;
                end
            end
            ST_PLAY: begin
                if (level_cleared) begin
                    st_nxt = ST_WIN;
                end else if (loss_edge) begin
                    // a bonus landing on the same cycle cancels the lost life
                    if (bonus_life || (lives > LIVES_W'(1))) begin
                        lives_nxt = bonus_life ? lives : lives - LIVES_W'(1);
                        tmr_load  = 1'b1;
                        st_nxt    = ST_RESPAWN;
                    end else begin
                        lives_nxt = '0;
                        st_nxt    = ST_GAME_OVER;
                    end
                end else if (bonus_life) begin
                    lives_nxt = lives_inc;
                end
            end
            ST_RESPAWN: begin
                if (bonus_life) begin
                    lives_nxt = lives_inc;
                end
                if (tmr_expired) begin
                    st_nxt    = ST_PLAY;
                    pulse_nxt = 1'b1;
                end
            end
            ST_GAME_OVER, ST_WIN: begin
                if (start_game) begin
                    lives_nxt = LIVES_W'(INIT_LIVES);
                    st_nxt    = ST_PLAY;
                    pulse_nxt = 1'b1;
                end
            end
            default: begin
                st_nxt    = ST_IDLE;
                lives_nxt = LIVES_W'(INIT_LIVES);
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            st_q          <= ST_IDLE;
            lives         <= LIVES_W'(INIT_LIVES);
            lost_q        <= 1'b0;
            ball_enable   <= 1'b0;
            respawn_pulse <= 1'b0;
            flash         <= 1'b0;
            game_over     <= 1'b0;
            win           <= 1'b0;
        end else begin
            st_q          <= st_nxt;
            lives         <= lives_nxt;
            lost_q        <= ball_lost;
            ball_enable   <= (st_nxt == ST_PLAY);
            respawn_pulse <= pulse_nxt;
            flash         <= (st_nxt == ST_RESPAWN) && tmr_count_nxt[3];
            game_over     <= (st_nxt == ST_GAME_OVER);
            win           <= (st_nxt == ST_WIN);
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller using default parameters (3 lives, max 9, 60 frames).
module tb_game_state_controller;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       start_game = 1'b0;
    logic       ball_lost = 1'b0;
    logic       bonus_life = 1'b0;
    logic       level_cleared = 1'b0;
    logic [3:0] lives;
    logic [2:0] state;
    logic       ball_enable;
    logic       respawn_pulse;
    logic       flash;
    logic       game_over;
    logic       win;

    int total = 0;
    int bad = 0;

    game_state_controller dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .start_game    (start_game),
        .ball_lost     (ball_lost),
        .bonus_life    (bonus_life),
        .level_cleared (level_cleared),
        .lives         (lives),
        .state         (state),
        .ball_enable   (ball_enable),
        .respawn_pulse (respawn_pulse),
        .flash         (flash),
        .game_over     (game_over),
        .win           (win)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            cyc();
            if (respawn_pulse === 1'b1) p++;
            startOfFrame = 1'b0;
            cyc();
            if (respawn_pulse === 1'b1) p++;
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        cyc();
        cyc();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if (lives !== 4'd3) begin bad++; $display("FAIL reset_lives: got %0d want 3", lives); end
        total++; if ({ball_enable, respawn_pulse, flash, game_over, win} !== 5'b0) begin bad++; $display("FAIL reset_outputs: got %b want 00000", {ball_enable, respawn_pulse, flash, game_over, win}); end
        resetN = 1'b1;
        cyc();
        bonus_life = 1'b1;
        cyc();
        bonus_life = 1'b0;
        total++; if (lives !== 4'd3) begin bad++; $display("FAIL idle_bonus_ignored: got %0d want 3", lives); end
        cyc();
    endtask

    task automatic test_start();
        start_game = 1'b1;
        cyc();
        start_game = 1'b0;
        total++; if (state !== 3'd1) begin bad++; $display("FAIL start_state: got %0d want 1", state); end
        total++; if (lives !== 4'd3) begin bad++; $display("FAIL start_lives: got %0d want 3", lives); end
        total++; if (ball_enable !== 1'b1) begin bad++; $display("FAIL start_ball_enable: got %b want 1", ball_enable); end
        total++; if (respawn_pulse !== 1'b1) begin bad++; $display("FAIL start_pulse: got %b want 1", respawn_pulse); end
        cyc();
        total++; if (respawn_pulse !== 1'b0) begin bad++; $display("FAIL start_pulse_width: got %b want 0", respawn_pulse); end
        start_game = 1'b1;
        cyc();
        start_game = 1'b0;
        total++; if ({state, respawn_pulse} !== {3'd1, 1'b0}) begin bad++; $display("FAIL play_start_ignored: got state=%0d pulse=%b want state=1 pulse=0", state, respawn_pulse); end
        cyc();
    endtask

    task automatic test_ball_loss_held();
        int p;
        ball_lost = 1'b1;
        cyc();
        total++; if ({state, lives} !== {3'd2, 4'd2}) begin bad++; $display("FAIL loss_enter: got state=%0d lives=%0d want state=2 lives=2", state, lives); end
        total++; if ({ball_enable, flash} !== 2'b01) begin bad++; $display("FAIL loss_flags: got ball_enable=%b flash=%b want 0 1", ball_enable, flash); end
        for (int i = 0; i < 9; i++) cyc();
        ball_lost = 1'b0;
        total++; if (lives !== 4'd2) begin bad++; $display("FAIL loss_held_once: got %0d want 2", lives); end
        frames(5, p);
        total++; if (flash !== 1'b0) begin bad++; $display("FAIL flash_timer55: got %b want 0", flash); end
        start_game = 1'b1; cyc(); start_game = 1'b0;
        ball_lost = 1'b1; cyc(); ball_lost = 1'b0; cyc();
        level_cleared = 1'b1; cyc(); level_cleared = 1'b0;
        total++; if ({state, lives} !== {3'd2, 4'd2}) begin bad++; $display("FAIL respawn_ignores: got state=%0d lives=%0d want state=2 lives=2", state, lives); end
        frames(54, p);
        total++; if ({state, p} !== {3'd2, 32'd0}) begin bad++; $display("FAIL respawn_59frames: got state=%0d pulses=%0d want state=2 pulses=0", state, p); end
        frames(1, p);
        total++; if ({state, p} !== {3'd1, 32'd1}) begin bad++; $display("FAIL respawn_done: got state=%0d pulses=%0d want state=1 pulses=1", state, p); end
    endtask

    task automatic test_game_over();
        int p;
        ball_lost = 1'b1; cyc(); ball_lost = 1'b0;
        total++; if ({state, lives} !== {3'd2, 4'd1}) begin bad++; $display("FAIL second_loss: got state=%0d lives=%0d want state=2 lives=1", state, lives); end
        frames(60, p);
        total++; if ({state, p} !== {3'd1, 32'd1}) begin bad++; $display("FAIL second_respawn: got state=%0d pulses=%0d want state=1 pulses=1", state, p); end
        ball_lost = 1'b1; cyc(); ball_lost = 1'b0;
        total++; if ({state, lives, game_over, ball_enable} !== {3'd3, 4'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL game_over: got state=%0d lives=%0d go=%b en=%b want 3 0 1 0", state, lives, game_over, ball_enable); end
        cyc();
        bonus_life = 1'b1; cyc(); bonus_life = 1'b0;
        total++; if ({state, lives} !== {3'd3, 4'd0}) begin bad++; $display("FAIL game_over_hold: got state=%0d lives=%0d want state=3 lives=0", state, lives); end
        start_game = 1'b1; cyc(); start_game = 1'b0;
        total++; if ({state, lives, respawn_pulse, game_over} !== {3'd1, 4'd3, 1'b1, 1'b0}) begin bad++; $display("FAIL restart: got state=%0d lives=%0d pulse=%b go=%b want 1 3 1 0", state, lives, respawn_pulse, game_over); end
        cyc();
    endtask

    task automatic test_bonus_with_loss();
        int p;
        ball_lost = 1'b1; cyc(); ball_lost = 1'b0; frames(60, p);
        ball_lost = 1'b1; cyc(); ball_lost = 1'b0; frames(60, p);
        total++; if ({state, lives} !== {3'd1, 4'd1}) begin bad++; $display("FAIL one_life_play: got state=%0d lives=%0d want state=1 lives=1", state, lives); end
        ball_lost = 1'b1; bonus_life = 1'b1; cyc(); ball_lost = 1'b0; bonus_life = 1'b0;
        total++; if ({state, lives, game_over} !== {3'd2, 4'd1, 1'b0}) begin bad++; $display("FAIL bonus_saves: got state=%0d lives=%0d go=%b want 2 1 0", state, lives, game_over); end
        bonus_life = 1'b1; cyc(); bonus_life = 1'b0;
        total++; if (lives !== 4'd2) begin bad++; $display("FAIL respawn_bonus: got %0d want 2", lives); end
        frames(60, p);
        total++; if ({state, p} !== {3'd1, 32'd1}) begin bad++; $display("FAIL bonus_respawn_done: got state=%0d pulses=%0d want state=1 pulses=1", state, p); end
    endtask

    task automatic test_saturate();
        resetN = 1'b0; cyc(); resetN = 1'b1; cyc();
        start_game = 1'b1; cyc(); start_game = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bonus_life = 1'b1; cyc(); bonus_life = 1'b0; cyc();
        end
        total++; if (lives !== 4'd9) begin bad++; $display("FAIL bonus_saturate: got %0d want 9", lives); end
    endtask

    task automatic test_win();
        level_cleared = 1'b1; ball_lost = 1'b1; cyc(); level_cleared = 1'b0; ball_lost = 1'b0;
        total++; if ({state, lives, win, ball_enable} !== {3'd4, 4'd9, 1'b1, 1'b0}) begin bad++; $display("FAIL win_priority: got state=%0d lives=%0d win=%b en=%b want 4 9 1 0", state, lives, win, ball_enable); end
        cyc(); cyc(); cyc();
        total++; if (state !== 3'd4) begin bad++; $display("FAIL win_hold: got %0d want 4", state); end
        start_game = 1'b1; cyc(); start_game = 1'b0;
        total++; if ({state, lives, respawn_pulse, win} !== {3'd1, 4'd3, 1'b1, 1'b0}) begin bad++; $display("FAIL win_restart: got state=%0d lives=%0d pulse=%b win=%b want 1 3 1 0", state, lives, respawn_pulse, win); end
        cyc();
    endtask

    task automatic test_reset_mid_respawn();
        int p;
        ball_lost = 1'b1; cyc(); ball_lost = 1'b0;
        frames(30, p);
        total++; if ({state, flash} !== {3'd2, 1'b1}) begin bad++; $display("FAIL timer30_flash: got state=%0d flash=%b want 2 1", state, flash); end
        #2 resetN = 1'b0;
        #1;
        total++; if ({state, lives, flash, ball_enable} !== {3'd0, 4'd3, 1'b0, 1'b0}) begin bad++; $display("FAIL async_reset: got state=%0d lives=%0d flash=%b en=%b want 0 3 0 0", state, lives, flash, ball_enable); end
        cyc(); cyc();
        resetN = 1'b1;
        frames(40, p);
        total++; if ({state, p} !== {3'd0, 32'd0}) begin bad++; $display("FAIL no_residual_pulse: got state=%0d pulses=%0d want state=0 pulses=0", state, p); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start();
        test_ball_loss_held();
        test_game_over();
        test_bonus_with_loss();
        test_saturate();
        test_win();
        test_reset_mid_respawn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
